// File: rtl/spi_target_port_if.sv
// Byte-stream side of the SPI target port.
// slave is the port itself, master is the user logic.
interface spi_target_port_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       rx_overflow_o;
    logic       cs_active_o;

    modport slave (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i,
        input  tx_data_i,
        input  tx_valid_i,
        output tx_ready_o,
        output rx_overflow_o,
        output cs_active_o
    );

    modport master (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i,
        output tx_data_i,
        output tx_valid_i,
        input  tx_ready_o,
        input  rx_overflow_o,
        input  cs_active_o
    );
endinterface

// File: rtl/spi_target_port.sv
// SPI mode-0 target with byte streams and a small receive FIFO.
// Pins are registered once; all SPI edges are seen in the clk_i domain.
module spi_target_port #(
    parameter int          RX_DEPTH  = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_csb_i,
    input  logic spi_sdi_i,
    output logic spi_sdo_o,
    output logic spi_sdo_en_o,
    spi_target_port_if.slave bus
);

    localparam int AW = $clog2(RX_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q, state_d;

    logic       sck_q, sck_q2, csb_q, sdi_q;
    logic       in_vld_q, hi_seen_q;
    logic [2:0] cnt_q;
    logic       done_q;
    logic [7:0] tx_sh_q, rx_sh_q;
    logic [7:0] mem_q [RX_DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    logic       enter, leave, active;
    logic       sck_rise, sck_fall;
    logic       rise_act, fall_act, wrap;
    logic       load_tx, shift_tx;
    logic       full, empty, push, pop, ovf;
    logic [7:0] rx_byte;

    // hi_seen_q: csb must be seen high on real pins before a new select
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q     <= 1'b0;
            sck_q2    <= 1'b0;
            csb_q     <= 1'b1;
            sdi_q     <= 1'b0;
            in_vld_q  <= 1'b0;
            hi_seen_q <= 1'b0;
        end else begin
            sck_q     <= spi_sck_i;
            sck_q2    <= sck_q;
            csb_q     <= spi_csb_i;
            sdi_q     <= spi_sdi_i;
            in_vld_q  <= 1'b1;
            hi_seen_q <= hi_seen_q | (in_vld_q & csb_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hi_seen_q && !csb_q) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                end
            end
            ACTIVE: begin
                if (csb_q) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active   = (state_q == ACTIVE);
    assign sck_rise = sck_q & ~sck_q2;
    assign sck_fall = ~sck_q & sck_q2;
    assign rise_act = active & ~csb_q & sck_rise;
    assign fall_act = active & ~csb_q & sck_fall;
    assign wrap     = rise_act & (cnt_q == 3'd7);
    assign rx_byte  = {rx_sh_q[6:0], sdi_q};

    assign load_tx  = enter
                    | (fall_act & (cnt_q == 3'd0) & done_q);
    assign shift_tx = fall_act & ~load_tx;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW])
                 && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = ~empty & bus.rx_ready_i;
    // a pop in the same cycle frees the slot for a push into a full FIFO
    assign push  = wrap & (~full | pop);
    assign ovf   = wrap & ~push;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            tx_sh_q <= IDLE_BYTE;
            rx_sh_q <= 8'h00;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (enter || leave) begin
                cnt_q   <= 3'd0;
                done_q  <= 1'b0;
                rx_sh_q <= 8'h00;
            end else if (rise_act) begin
                cnt_q   <= cnt_q + 3'd1;
                rx_sh_q <= rx_byte;
                if (wrap) done_q <= 1'b1;
            end
            if (load_tx) begin
                tx_sh_q <= bus.tx_valid_i ? bus.tx_data_i
                                          : IDLE_BYTE;
            end else if (shift_tx) begin
                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wptr_q[AW-1:0]] <= rx_byte;
    end

    assign spi_sdo_o         = active ? tx_sh_q[7] : 1'b1;
    assign spi_sdo_en_o      = active;
    assign bus.cs_active_o   = active;
    assign bus.rx_valid_o    = ~empty;
    assign bus.rx_data_o     = empty ? 8'h00
                             : mem_q[rptr_q[AW-1:0]];
    assign bus.tx_ready_o    = ~rst_i & load_tx & bus.tx_valid_i;
    assign bus.rx_overflow_o = ~rst_i & ovf;

endmodule
